// File: rtl/trax_board_engine.sv
// Trax board store and placement checker: validates one tile at a time, derives its colour from neighbours, tracks the bounding box.
// Circular physical array indexed by the low coordinate bits; anything outside the box reads as empty so aliased cells stay hidden.
module trax_board_engine #(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       place_valid,
  output logic                       place_ready,
  input  logic [1:0]                 place_type,
  input  logic signed [ROW_BITS:0]   place_row,
  input  logic signed [COL_BITS:0]   place_col,
  output logic                       place_done,
  output logic [2:0]                 place_status,
  output logic [2:0]                 place_cell,
  input  logic                       rd_en,
  input  logic signed [ROW_BITS:0]   rd_row,
  input  logic signed [COL_BITS:0]   rd_col,
  output logic                       rd_valid,
  output logic [2:0]                 rd_data,
  output logic signed [ROW_BITS:0]   row_min,
  output logic signed [ROW_BITS:0]   row_max,
  output logic signed [COL_BITS:0]   col_min,
  output logic signed [COL_BITS:0]   col_max,
  output logic [ROW_BITS+COL_BITS:0] tile_count
);
  localparam int AW = ROW_BITS + COL_BITS;
  // Two guard bits so neighbour offsets and box spans never overflow.
  localparam int RW = ROW_BITS + 3;
  localparam int CW = COL_BITS + 3;
  localparam logic signed [RW-1:0] R_ONE  = RW'(1);
  localparam logic signed [CW-1:0] C_ONE  = CW'(1);
  localparam logic signed [RW-1:0] R_SPAN = RW'(2**ROW_BITS);
  localparam logic signed [CW-1:0] C_SPAN = CW'(2**COL_BITS);
  localparam logic [2:0] ST_OK = 3'd0, ST_OCC = 3'd1, ST_NONB = 3'd2,
                         ST_OOR = 3'd3, ST_CONF = 3'd4, ST_BADT = 3'd5;

  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_RD_N, S_RD_E, S_RD_S, S_RD_W, S_EVAL, S_COMMIT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]               mem [2**AW];
  logic [AW-1:0]            clr_addr;
  logic [1:0]               req_type;
  logic signed [ROW_BITS:0] req_row;
  logic signed [COL_BITS:0] req_col;
  logic [2:0]               nbr [4];
  logic [2:0]               eval_status, eval_cell;

  logic signed [RW-1:0] tr, rr, b_rmin, b_rmax, n_rmin, n_rmax;
  logic signed [CW-1:0] tc, rc, b_cmin, b_cmax, n_cmin, n_cmax;
  logic                 board_empty, in_box, out_rng, any_nbr, conflict, need_c, c_d;
  logic [1:0]           dir;
  logic [2:0]           rd_cell, st, new_cell;
  logic                 rd_accept;

  function automatic logic signed [RW-1:0] sxr(input logic signed [ROW_BITS:0] v);
    return {{2{v[ROW_BITS]}}, v};
  endfunction

  function automatic logic signed [CW-1:0] sxc(input logic signed [COL_BITS:0] v);
    return {{2{v[COL_BITS]}}, v};
  endfunction

  // 1 when the edge in direction d (0 N, 1 E, 2 S, 3 W) carries ~c rather than c.
  function automatic logic edge_inv(input logic [1:0] t, input logic [1:0] d);
    case (t)
      2'b01:   return d[0];
      2'b10:   return (d == 2'd1) || (d == 2'd2);
      default: return d[1];
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR:  if (clr_addr == '1) state_nxt = S_IDLE;
      S_IDLE:   if (place_valid) state_nxt = S_RD_N;
      S_RD_N:   state_nxt = S_RD_E;
      S_RD_E:   state_nxt = S_RD_S;
      S_RD_S:   state_nxt = S_RD_W;
      S_RD_W:   state_nxt = S_EVAL;
      S_EVAL:   state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    place_ready = (state == S_IDLE);
    place_done  = (state == S_DONE);
  end

  // Single read port: rd coordinates in IDLE, neighbours in RD_*, target in EVAL.
  always_comb begin
    tr = sxr(req_row);
    tc = sxc(req_col);
    rr = tr;
    rc = tc;
    case (state)
      S_IDLE: begin rr = sxr(rd_row); rc = sxc(rd_col); end
      S_RD_N: rr = tr - R_ONE;
      S_RD_E: rc = tc + C_ONE;
      S_RD_S: rr = tr + R_ONE;
      S_RD_W: rc = tc - C_ONE;
      default: ;
    endcase
    b_rmin = sxr(row_min);
    b_rmax = sxr(row_max);
    b_cmin = sxc(col_min);
    b_cmax = sxc(col_max);
    board_empty = (tile_count == '0);
    in_box  = !board_empty && rr >= b_rmin && rr <= b_rmax && rc >= b_cmin && rc <= b_cmax;
    rd_cell = in_box ? mem[{rr[ROW_BITS-1:0], rc[COL_BITS-1:0]}] : 3'b000;
    rd_accept = (state == S_IDLE) && rd_en && !place_valid;
  end

  always_comb begin
    any_nbr  = 1'b0;
    conflict = 1'b0;
    need_c   = 1'b0;
    c_d      = 1'b0;
    dir      = 2'd0;
    for (int d = 0; d < 4; d++) begin
      dir = 2'(d);
      if (nbr[d][2:1] != 2'b00) begin
        c_d = nbr[d][0] ^ edge_inv(nbr[d][2:1], dir ^ 2'd2) ^ edge_inv(req_type, dir);
        if (!any_nbr) need_c = c_d;
        else if (c_d != need_c) conflict = 1'b1;
        any_nbr = 1'b1;
      end
    end
    n_rmin = (tr < b_rmin) ? tr : b_rmin;
    n_rmax = (tr > b_rmax) ? tr : b_rmax;
    n_cmin = (tc < b_cmin) ? tc : b_cmin;
    n_cmax = (tc > b_cmax) ? tc : b_cmax;
    if (board_empty)
      out_rng = (req_row != '0) || (req_col != '0);
    else
      out_rng = (tr < b_rmin - R_ONE) || (tr > b_rmax + R_ONE) ||
                (tc < b_cmin - C_ONE) || (tc > b_cmax + C_ONE) ||
                (n_rmax - n_rmin >= R_SPAN) || (n_cmax - n_cmin >= C_SPAN);
    if (req_type == 2'b00)                st = ST_BADT;
    else if (out_rng)                     st = ST_OOR;
    else if (rd_cell[2:1] != 2'b00)       st = ST_OCC;
    else if (!board_empty && !any_nbr)    st = ST_NONB;
    else if (!board_empty && conflict)    st = ST_CONF;
    else                                  st = ST_OK;
    new_cell = {req_type, board_empty ? 1'b0 : need_c};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_addr     <= '0;
      req_type     <= 2'b00;
      req_row      <= '0;
      req_col      <= '0;
      for (int i = 0; i < 4; i++) nbr[i] <= 3'b000;
      eval_status  <= ST_OK;
      eval_cell    <= 3'b000;
      place_status <= ST_OK;
      place_cell   <= 3'b000;
      rd_valid     <= 1'b0;
      rd_data      <= 3'b000;
      row_min      <= '0;
      row_max      <= '0;
      col_min      <= '0;
      col_max      <= '0;
      tile_count   <= '0;
    end else begin
      rd_valid <= rd_accept;
      rd_data  <= rd_accept ? rd_cell : 3'b000;
      case (state)
        S_CLEAR: clr_addr <= clr_addr + AW'(1);
        S_IDLE: if (place_valid) begin
          req_type <= place_type;
          req_row  <= place_row;
          req_col  <= place_col;
        end
        S_RD_N: nbr[0] <= rd_cell;
        S_RD_E: nbr[1] <= rd_cell;
        S_RD_S: nbr[2] <= rd_cell;
        S_RD_W: nbr[3] <= rd_cell;
        S_EVAL: begin
          eval_status <= st;
          eval_cell   <= (st == ST_OK) ? new_cell : 3'b000;
        end
        S_COMMIT: begin
          place_status <= eval_status;
          place_cell   <= eval_cell;
          if (eval_status == ST_OK) begin
            tile_count <= tile_count + (AW+1)'(1);
            if (board_empty) begin
              row_min <= '0; row_max <= '0; col_min <= '0; col_max <= '0;
            end else begin
              if (req_row < row_min) row_min <= req_row;
              if (req_row > row_max) row_max <= req_row;
              if (req_col < col_min) col_min <= req_col;
              if (req_col > col_max) col_max <= req_col;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is wiped by CLEAR rather than by reset.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)
      mem[clr_addr] <= 3'b000;
    else if (state == S_COMMIT && eval_status == ST_OK)
      mem[{req_row[ROW_BITS-1:0], req_col[COL_BITS-1:0]}] <= eval_cell;
  end

endmodule

// File: tb/tb_trax_board_engine.sv
// Directed bench for trax_board_engine: a 32x32 board and a 4x8 board share stimulus, one held in reset at a time.
module tb_trax_board_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_m = 1'b0, rst_s = 1'b0;
  logic       p_valid = 1'b0, rd_en = 1'b0;
  logic [1:0] p_type = 2'b00;
  logic [5:0] p_row = '0, p_col = '0, rd_row = '0, rd_col = '0;
  int         sel = 0;
  int         n_checks = 0, n_fail = 0;

  logic        m_ready, m_done, m_rdv, s_ready, s_done, s_rdv;
  logic [2:0]  m_status, m_cell, m_rdd, s_status, s_cell, s_rdd;
  logic [5:0]  m_rmin, m_rmax, m_cmin, m_cmax;
  logic [2:0]  s_rmin, s_rmax;
  logic [3:0]  s_cmin, s_cmax;
  logic [10:0] m_cnt;
  logic [5:0]  s_cnt;

  trax_board_engine #(.ROW_BITS(5), .COL_BITS(5)) dut (
    .clk(clk), .reset(rst_m), .place_valid(p_valid), .place_ready(m_ready),
    .place_type(p_type), .place_row(p_row), .place_col(p_col),
    .place_done(m_done), .place_status(m_status), .place_cell(m_cell),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_valid(m_rdv), .rd_data(m_rdd),
    .row_min(m_rmin), .row_max(m_rmax), .col_min(m_cmin), .col_max(m_cmax), .tile_count(m_cnt)
  );

  trax_board_engine #(.ROW_BITS(2), .COL_BITS(3)) dut_s (
    .clk(clk), .reset(rst_s), .place_valid(p_valid), .place_ready(s_ready),
    .place_type(p_type), .place_row(p_row[2:0]), .place_col(p_col[3:0]),
    .place_done(s_done), .place_status(s_status), .place_cell(s_cell),
    .rd_en(rd_en), .rd_row(rd_row[2:0]), .rd_col(rd_col[3:0]), .rd_valid(s_rdv), .rd_data(s_rdd),
    .row_min(s_rmin), .row_max(s_rmax), .col_min(s_cmin), .col_max(s_cmax), .tile_count(s_cnt)
  );

  logic        o_ready, o_done, o_rdv;
  logic [2:0]  o_status, o_cell, o_rdd;
  logic [5:0]  o_rmin, o_rmax, o_cmin, o_cmax;
  logic [10:0] o_cnt;
  logic [46:0] o_all;

  always_comb begin
    o_ready = m_ready; o_done = m_done; o_rdv = m_rdv;
    o_status = m_status; o_cell = m_cell; o_rdd = m_rdd;
    o_rmin = m_rmin; o_rmax = m_rmax; o_cmin = m_cmin; o_cmax = m_cmax; o_cnt = m_cnt;
    if (sel != 0) begin
      o_ready = s_ready; o_done = s_done; o_rdv = s_rdv;
      o_status = s_status; o_cell = s_cell; o_rdd = s_rdd;
      o_rmin = {{3{s_rmin[2]}}, s_rmin}; o_rmax = {{3{s_rmax[2]}}, s_rmax};
      o_cmin = {{2{s_cmin[3]}}, s_cmin}; o_cmax = {{2{s_cmax[3]}}, s_cmax};
      o_cnt = {5'd0, s_cnt};
    end
    o_all = {o_ready, o_done, o_rdv, o_status, o_cell, o_rdd, o_rmin, o_rmax, o_cmin, o_cmax, o_cnt};
  end

  localparam logic [2:0] OK = 3'd0, OCC = 3'd1, NONB = 3'd2, OOR = 3'd3, CONF = 3'd4, BADT = 3'd5;
  localparam logic [1:0] PLUS = 2'b01, SLASH = 2'b10;

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!o_ready && n < 3000) begin @(posedge clk); #1; n++; end
    if (!o_ready) begin
      n_checks++; n_fail++;
      $display("FAIL %s ready timeout: place_ready=%b after %0d cycles, required 1", nm, o_ready, n);
    end
  endtask

  task automatic do_place(input logic [1:0] t, input int r, input int c, input logic [2:0] es,
                          input logic [2:0] ec, input bit with_rd, input string nm);
    int early;
    wait_ready(nm);
    p_type = t; p_row = 6'(r); p_col = 6'(c); p_valid = 1'b1;
    rd_row = 6'(r); rd_col = 6'(c); rd_en = with_rd;
    @(posedge clk); #1;
    p_valid = 1'b0; rd_en = 1'b0;
    if (with_rd) begin
      n_checks++;
      if (o_rdv !== 1'b0) begin
        n_fail++; $display("FAIL %s dropped read: rd_valid=%b, required 0", nm, o_rdv);
      end
    end
    early = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k < 6 && o_done) early++;
    end
    n_checks++;
    if (o_done !== 1'b1 || early != 0) begin
      n_fail++; $display("FAIL %s latency: done=%b early=%0d, required done=1 early=0", nm, o_done, early);
    end
    n_checks++;
    if (o_status !== es) begin
      n_fail++; $display("FAIL %s status: got %0d, required %0d", nm, o_status, es);
    end
    n_checks++;
    if (o_cell !== ec) begin
      n_fail++; $display("FAIL %s cell: got %b, required %b", nm, o_cell, ec);
    end
    @(posedge clk); #1;
    n_checks++;
    if (o_ready !== 1'b1 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL %s return to idle: ready=%b done=%b, required 1/0", nm, o_ready, o_done);
    end
  endtask

  task automatic do_read(input int r, input int c, input logic [2:0] e, input string nm);
    wait_ready(nm);
    rd_row = 6'(r); rd_col = 6'(c); rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    n_checks++;
    if (o_rdv !== 1'b1 || o_rdd !== e) begin
      n_fail++; $display("FAIL %s read: valid=%b data=%b, required 1/%b", nm, o_rdv, o_rdd, e);
    end
    @(posedge clk); #1;
    n_checks++;
    if (o_rdv !== 1'b0) begin
      n_fail++; $display("FAIL %s read pulse: rd_valid=%b one cycle later, required 0", nm, o_rdv);
    end
  endtask

  task automatic check_box(input int rmin, input int rmax, input int cmin, input int cmax,
                           input int cnt, input string nm);
    logic [5:0]  e_rmin, e_rmax, e_cmin, e_cmax;
    logic [10:0] e_cnt;
    e_rmin = 6'(rmin); e_rmax = 6'(rmax); e_cmin = 6'(cmin); e_cmax = 6'(cmax); e_cnt = 11'(cnt);
    n_checks++;
    if ({o_rmin, o_rmax, o_cmin, o_cmax} !== {e_rmin, e_rmax, e_cmin, e_cmax}) begin
      n_fail++;
      $display("FAIL %s box: got r %0d..%0d c %0d..%0d, required r %0d..%0d c %0d..%0d", nm,
               $signed(o_rmin), $signed(o_rmax), $signed(o_cmin), $signed(o_cmax), rmin, rmax, cmin, cmax);
    end
    n_checks++;
    if (o_cnt !== e_cnt) begin
      n_fail++; $display("FAIL %s tile_count: got %0d, required %0d", nm, o_cnt, cnt);
    end
  endtask

  task automatic reset_dut(input int s, input string nm);
    int n, clr;
    sel = s;
    p_valid = 1'b0; rd_en = 1'b0;
    rst_m = 1'b0; rst_s = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (o_all !== '0) begin
      n_fail++; $display("FAIL %s reset outputs: got %h, required 0", nm, o_all);
    end
    clr = (s == 0) ? 1024 : 32;
    @(negedge clk);
    if (s == 0) rst_m = 1'b1; else rst_s = 1'b1;
    n = 0;
    while (n < 3000) begin
      @(posedge clk); #1; n++;
      if (o_ready) break;
    end
    n_checks++;
    if (n != clr) begin
      n_fail++; $display("FAIL %s clear length: ready after %0d cycles, required %0d", nm, n, clr);
    end
  endtask

  task automatic test_reset;
    reset_dut(0, "reset");
    check_box(0, 0, 0, 0, 0, "reset idle");
  endtask

  task automatic test_basic;
    do_place(PLUS, 0, 0, OK, 3'b010, 0, "first plus");
    check_box(0, 0, 0, 0, 1, "first plus");
    do_place(SLASH, 0, 1, OK, 3'b101, 0, "slash east");
    check_box(0, 0, 0, 1, 2, "slash east");
    do_place(PLUS, 0, 0, OCC, 3'b000, 0, "occupied");
    do_place(PLUS, -1, -1, NONB, 3'b000, 0, "no neighbour");
    do_place(PLUS, 0, 5, OOR, 3'b000, 0, "out of range");
    check_box(0, 0, 0, 1, 2, "after rejects");
  endtask

  task automatic test_colour;
    reset_dut(0, "colour reset");
    do_place(PLUS, 1, 1, OOR, 3'b000, 0, "first off origin");
    do_place(PLUS, 0, 0, OK, 3'b010, 0, "c plus 00");
    do_place(PLUS, 1, 0, OK, 3'b010, 0, "c plus 10");
    do_place(PLUS, 0, 1, OK, 3'b010, 0, "c plus 01");
    do_place(SLASH, 1, 1, CONF, 3'b000, 0, "colour conflict");
    do_place(PLUS, 1, 1, OK, 3'b010, 0, "c plus 11");
    do_place(2'b00, 2, 0, BADT, 3'b000, 0, "bad type");
    check_box(0, 1, 0, 1, 4, "colour board");
  endtask

  task automatic test_small_board;
    reset_dut(1, "small reset");
    for (int r = 0; r < 4; r++) do_place(PLUS, r, 0, OK, 3'b010, 0, "small column");
    do_place(PLUS, -1, 0, OOR, 3'b000, 0, "small height");
    check_box(0, 3, 0, 0, 4, "small box");
    do_read(-1, 0, 3'b000, "small rd -1");
    do_read(4, 0, 3'b000, "small rd alias");
    do_read(3, 0, 3'b010, "small rd 3");
  endtask

  task automatic test_negative_growth;
    reset_dut(0, "negative reset");
    do_place(PLUS, 0, 0, OK, 3'b010, 0, "neg 0");
    do_place(PLUS, -1, 0, OK, 3'b010, 0, "neg -1");
    do_place(PLUS, -2, 0, OK, 3'b010, 0, "neg -2");
    check_box(-2, 0, 0, 0, 3, "negative box");
    do_read(-2, 0, 3'b010, "rd wrapped");
  endtask

  task automatic test_back_to_back;
    do_place(PLUS, 1, 0, OK, 3'b010, 1, "place beats read");
    do_place(SLASH, -2, 1, OK, 3'b101, 0, "back to back");
    check_box(-2, 1, 0, 1, 5, "back to back");
  endtask

  task automatic test_reset_midflight;
    int n, dones;
    do_place(PLUS, 0, 0, OCC, 3'b000, 0, "pre-reset reject");
    wait_ready("midflight");
    p_type = PLUS; p_row = 6'(2); p_col = 6'(0); p_valid = 1'b1;
    @(posedge clk); #1;
    p_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_m = 1'b0;
    #1;
    n_checks++;
    if (o_all !== '0) begin
      n_fail++; $display("FAIL midflight reset outputs: got %h, required 0", o_all);
    end
    @(negedge clk); @(negedge clk);
    rst_m = 1'b1;
    n = 0; dones = 0;
    while (n < 3000) begin
      @(posedge clk); #1; n++;
      if (o_done) dones++;
      if (o_ready) break;
    end
    n_checks++;
    if (n != 1024) begin
      n_fail++; $display("FAIL midflight clear length: ready after %0d cycles, required 1024", n);
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL midflight done: %0d pulses, required 0", dones);
    end
    do_read(0, 0, 3'b000, "midflight rd origin");
    check_box(0, 0, 0, 0, 0, "midflight");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_colour;
    test_small_board;
    test_negative_growth;
    test_back_to_back;
    test_reset_midflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/trax_board_engine.md
# trax_board_engine

Parametrised Trax board store and placement checker for the Trax player. It accepts one tile placement at a time in signed logical coordinates and derives the tile colour from its occupied neighbours. It rejects illegal placements with a status code and tracks the occupied bounding box. Physical storage is a circular 2^ROW_BITS × 2^COL_BITS array, so growth toward negative coordinates needs no row/column shifting.

## Interface
- ROW_BITS, 5: log2 physical rows; logical row is signed, ROW_BITS+1 bits.
- COL_BITS, 5: log2 physical columns; logical column is signed, COL_BITS+1 bits.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- place_valid  in  1  placement request.
- place_ready  out  1  high only in IDLE.
- place_type  in  2  01 plus, 10 slash, 11 bslash, 00 illegal.
- place_row / place_col  in  ROW_BITS+1 / COL_BITS+1  signed logical coordinates; row increases downward.
- place_done  out  1  one-cycle result pulse.
- place_status  out  3  0 OK, 1 OCCUPIED, 2 NO_NEIGHBOR, 3 OUT_OF_RANGE, 4 COLOR_CONFLICT, 5 BAD_TYPE; held until the next place_done.
- place_cell  out  3  cell written ({type,colour}); 0 when rejected.
- rd_en  in  1  board read, honoured only in IDLE.
- rd_row / rd_col  in  ROW_BITS+1 / COL_BITS+1  signed read coordinates.
- rd_valid / rd_data  out  1 / 3  read result, valid the cycle after an accepted rd_en.
- row_min, row_max / col_min, col_max  out  ROW_BITS+1 / COL_BITS+1  signed bounding box.
- tile_count  out  ROW_BITS+COL_BITS+1  number of placed tiles.

## Operation
- Cell encoding: [2:1] type (00 empty), [0] colour c = colour of the top edge.
- Edge colours:
  - plus: top = bottom = c, left = right = ~c.
  - slash: top = left = c, bottom = right = ~c.
  - bslash: top = right = c, left = bottom = ~c.
- Physical address = low ROW_BITS/COL_BITS of the logical coordinates (two's-complement wrap).
- Any cell outside the current bounding box reads as empty, on both the neighbour path and the rd path. This masks aliasing.
- States: CLEAR, IDLE, RD_N, RD_E, RD_S, RD_W, EVAL, COMMIT, DONE.
- CLEAR: after reset release, write 0 to every address, one per cycle, then go to IDLE.
- IDLE: place_valid & place_ready accepts a request and latches type, row and col. rd_en is serviced only when place_valid is low.
- RD_N/E/S/W read neighbours (r-1,c), (r,c+1), (r+1,c), (r,c-1) and the target cell, one read per state.
- EVAL checks in priority order:
  - BAD_TYPE: type 00.
  - OUT_OF_RANGE, board empty: target is not (0,0).
  - OUT_OF_RANGE, board not empty: target is outside [min-1,max+1] on either axis, or the new box height exceeds 2^ROW_BITS or width exceeds 2^COL_BITS.
  - OCCUPIED: target cell is not empty.
  - NO_NEIGHBOR: all four neighbours are empty.
  - COLOR_CONFLICT: occupied neighbours require different c.
  - Colour rule: each occupied neighbour requires c such that the new tile's facing edge equals the neighbour's opposite edge.
  - First tile: c = 0, no neighbour check.
- COMMIT: if OK, write the cell, update the bounding box (first tile sets all four to 0) and increment tile_count. Otherwise nothing changes.
- DONE: pulse place_done, then return to IDLE.

## Timing
- Reset values: place_ready 0, place_done 0, place_status 0, place_cell 0, rd_valid 0, rd_data 0, bounding box 0, tile_count 0, state CLEAR.
- CLEAR lasts 2^(ROW_BITS+COL_BITS) cycles; place_ready rises on the following cycle.
- Placement latency is fixed: accept on edge E0, place_done high during the cycle after E6. This is identical for legal and rejected placements. place_ready is high again after E7.
- Read: rd_en sampled in IDLE on edge R; rd_valid/rd_data high for the cycle after R.
- Simultaneous place_valid and rd_en in IDLE: the placement wins and the read is dropped (no rd_valid).
- Reset asserted in any state: all outputs go to reset values immediately; CLEAR restarts on release, and any in-flight placement is discarded without place_done.
- Status outputs and the bounding box change only on the DONE/COMMIT edges.

## Test plan
- Reset, wait for place_ready, place plus at (0,0) -> OK, place_cell 3'b010, box 0..0/0..0, tile_count 1.
- Place slash at (0,1) -> OK, place_cell 3'b101 (west edge must be 1), col_max 1. Place plus at (0,0) again -> OCCUPIED. Place plus at (-1,-1) -> NO_NEIGHBOR. Place plus at (0,5) -> OUT_OF_RANGE.
- Board plus (0,0), plus (1,0) -> 3'b010, plus (0,1) -> 3'b010. Slash at (1,1) -> COLOR_CONFLICT (N needs c=0, W needs c=1). Plus at (1,1) -> OK, 3'b010. Type 00 -> BAD_TYPE.
- ROW_BITS=2: plus at rows 0,1,2,3 of column 0 -> all OK. Row -1 -> OUT_OF_RANGE. rd (-1,0) and rd (4,0) -> rd_data 0. rd (3,0) -> 3'b010.
- Negative growth: plus at (0,0), (-1,0), (-2,0) -> row_min -2, row_max 0. rd (-2,0) -> 3'b010 via the wrapped address.
- Assert reset during RD_S: outputs zero at once, no place_done, place_ready low for 2^(ROW_BITS+COL_BITS) cycles. A read of (0,0) afterwards returns 0, and tile_count is 0.
